lcd_text_formatter: RTL and testbench
=====================================

Name: lcd_text_formatter

Overview:
- Successor to the fixed date/time LCD character generator. Renders a COLS x LINES text frame for the character LCD writer: the writer drives `index` and reads back one ASCII byte on `out`.
- A multi-cycle double-dabble converter turns the binary time fields into BCD.
- Fields are snapshotted on `load` and committed atomically to a double-buffered display, so a frame never tears.
- Adds 12h/AM-PM mode, stopwatch mode, blank mode and per-field blinking.

Parameters:
- COLS, 16, characters per line; must be >= 16.
- LINES, 2, number of display lines.
- IDX_W, 5, width of `index`; must satisfy 2^IDX_W >= COLS*LINES.
- FILL, 8'h20, character output for blank, padding, out-of-range and blinked positions.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  snapshot request; acted on only when busy=0.
- mode  in  2  layout select: 0 = date/24h, 1 = date/12h, 2 = stopwatch, 3 = blank.
- year  in  8  binary year offset from 2000, 0..255.
- month, day, hour, minute, second  in  8 each  binary field values.
- blink_sel  in  3  field to blink: 0 none, 1 year, 2 month, 3 day, 4 hour, 5 minute, 6 second, 7 none.
- blink_phase  in  1  when 1, the selected field's digits are output as FILL.
- index  in  IDX_W  character position; index = line*COLS + col.
- out  out  8  ASCII character, registered.
- busy  out  1  conversion in progress.
- valid  out  1  display buffer holds at least one completed conversion.

Behaviour:
- Reset (async, rst=1):
  - out=8'h00, busy=0, valid=0.
  - Shadow and display BCD buffers cleared to 0; display mode cleared to 0.
  - FSM returns to IDLE. This holds mid-conversion; any partial result is discarded.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: on load=1, capture year..second and mode into the shadow registers, then go to CONV.
  - 12h mapping is applied at capture when captured mode=1:
    - h = 12 if hour=0; h = hour-12 if hour>12; otherwise h = hour.
    - pm = (hour>=12).
  - CONV: shift-add-3 conversion over fields in the order year, month, day, hour, minute, second. Each field takes exactly 8 cycles, one bit per cycle, MSB first; add-3 applies to any nibble >=5 before each shift.
  - COMMIT: single cycle that copies all BCD results, pm and mode into the display buffer, then returns to IDLE.
- Busy/valid timing:
  - busy rises on the edge that samples load in IDLE and falls on the COMMIT edge: high 48 cycles conversion + 1 commit = 49 cycles.
  - valid is set on the first COMMIT and stays 1 until reset.
- load while busy=1 is ignored; there is no queuing.
- A load in the same cycle busy falls is also ignored. The next load is accepted on the following cycle.
- Width rules:
  - Non-year fields display tens/ones only (value mod 100); the hundreds digit is discarded.
  - Year displays hundreds/tens/ones.
- out latency: registered, 1 cycle from index. It uses only the display buffer, live blink_sel and live blink_phase; live fields and live mode are never used.
- Layout, display mode 0:
  - line 0: "DATE 2YYY/MM/DD ".
  - line 1: "TIME HH:MM:SS   ".
  - Digits are 8'h30+BCD.
- Layout, mode 1: as mode 0, but line 1 col 14..15 = "AM" (8'h41,8'h4D) or "PM" (8'h50,8'h4D). Col 13 = space.
- Layout, mode 2:
  - line 0: "STOPWATCH" then FILL.
  - line 1: as mode 0. blink_sel 1..3 has no visible effect.
- Layout, mode 3: every position is FILL.
- Padding:
  - cols 16..COLS-1 = FILL.
  - lines 2..LINES-1 = FILL.
  - index >= COLS*LINES = FILL.
- Blink: when blink_phase=1, the digit positions of blink_sel's field output FILL. Year blanks 3 digits; the leading '2' is never blanked. Separators and labels are unaffected.
- Before the first COMMIT, digits show '0' and the layout is mode 0.

Test Plan:
1. Reset, then load year=24, mon=3, day=7, hr=13, min=5, sec=59, mode=0 → busy high exactly 49 cycles, valid=1. Index 5..8 = "2024", index 10..14 = "03/07", index 21..28 = "13:05:59", each 1 cycle after index is applied.
2. Same fields with mode=1 → index 21,22 = 8'h30,8'h31 ("01"); index 30,31 = "PM". Reload with hr=0 → "12", "AM".
3. blink_sel=5 → index 24,25 = 8'h20 while blink_phase=1 and "05" while blink_phase=0. Index 23 stays ':'.
4. Second load pulsed 10 cycles into busy with different fields → ignored. Display shows the first snapshot; busy does not extend.
5. Assert rst during cycle 20 of CONV → out=0, busy=0, valid=0 immediately. Frame digits read '0'. A new load then completes normally.
6. mode=2 and mode=3 loads → line 0 reads "STOPWATCH" + FILL; mode 3 gives all 8'h20. Index 31 (COLS=16, LINES=2) and index 32 with IDX_W=6 both give 8'h20.

Source files
------------

// File: rtl/lcd_text_formatter_if.sv
// Bus between the character LCD writer and lcd_text_formatter: field inputs,
// snapshot handshake, and the indexed character read port.
interface lcd_text_formatter_if #(
  parameter int IDX_W = 5
);
  logic             load;
  logic [1:0]       mode;
  logic [7:0]       year;
  logic [7:0]       month;
  logic [7:0]       day;
  logic [7:0]       hour;
  logic [7:0]       minute;
  logic [7:0]       second;
  logic [2:0]       blink_sel;
  logic             blink_phase;
  logic [IDX_W-1:0] index;
  logic [7:0]       out;
  logic             busy;
  logic             valid;

  modport master (
    output load, mode, year, month, day, hour, minute, second,
    output blink_sel, blink_phase, index,
    input  out, busy, valid
  );

  modport slave (
    input  load, mode, year, month, day, hour, minute, second,
    input  blink_sel, blink_phase, index,
    output out, busy, valid
  );
endinterface

// File: rtl/lcd_text_formatter.sv
// Renders a COLS x LINES text frame from snapshotted date/time fields. Fields are
// converted to BCD serially (shift-add-3) and committed atomically to a display buffer.
module lcd_text_formatter #(
  parameter int         COLS  = 16,
  parameter int         LINES = 2,
  parameter int         IDX_W = 5,
  parameter logic [7:0] FILL  = 8'h20
) (
  input logic                 clk,
  input logic                 rst,
  lcd_text_formatter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  localparam int           TOTAL     = COLS * LINES;
  localparam logic [127:0] LINE0_TXT = "DATE 2YYY/MM/DD ";
  localparam logic [127:0] LINE1_TXT = "TIME HH:MM:SS   ";
  localparam logic [127:0] STOP_TXT  = "STOPWATCH       ";

  state_t      state_q, state_d;
  logic [2:0]  fld_q, fld_d;
  logic [2:0]  bit_q, bit_d;
  logic [11:0] work_q, work_d;
  logic [7:0]  sh_bin_q [6];
  logic [7:0]  sh_bin_d [6];
  logic [11:0] res_q [6];
  logic [11:0] res_d [6];
  logic [11:0] disp_bcd_q [6];
  logic [11:0] disp_bcd_d [6];
  logic [1:0]  sh_mode_q, sh_mode_d;
  logic [1:0]  disp_mode_q, disp_mode_d;
  logic        sh_pm_q, sh_pm_d;
  logic        disp_pm_q, disp_pm_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [7:0]  out_q, out_d;

  logic [11:0] adj;
  logic [11:0] shifted;
  logic [7:0]  cur_bin;
  logic [7:0]  hour12;
  logic [IDX_W-1:0] idx;

  assign idx       = bus.index;
  assign bus.out   = out_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;

  // Add-3 correction on every BCD nibble before the next shift.
  for (genvar gi = 0; gi < 3; gi++) begin : g_add3
    assign adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ? work_q[4*gi +: 4] + 4'd3
                                                         : work_q[4*gi +: 4];
  end

  assign cur_bin = sh_bin_q[fld_q];
  assign shifted = {adj[10:0], cur_bin[3'd7 - bit_q]};

  always_comb begin
    if (bus.hour == 8'd0)       hour12 = 8'd12;
    else if (bus.hour > 8'd12)  hour12 = bus.hour - 8'd12;
    else                        hour12 = bus.hour;
  end

  always_comb begin
    state_d     = state_q;
    fld_d       = fld_q;
    bit_d       = bit_q;
    work_d      = work_q;
    sh_bin_d    = sh_bin_q;
    res_d       = res_q;
    disp_bcd_d  = disp_bcd_q;
    sh_mode_d   = sh_mode_q;
    disp_mode_d = disp_mode_q;
    sh_pm_d     = sh_pm_q;
    disp_pm_d   = disp_pm_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          sh_bin_d[0] = bus.year;
          sh_bin_d[1] = bus.month;
          sh_bin_d[2] = bus.day;
          sh_bin_d[3] = (bus.mode == 2'd1) ? hour12 : bus.hour;
          sh_bin_d[4] = bus.minute;
          sh_bin_d[5] = bus.second;
          sh_mode_d   = bus.mode;
          sh_pm_d     = (bus.hour >= 8'd12);
          fld_d       = 3'd0;
          bit_d       = 3'd0;
          work_d      = 12'd0;
          busy_d      = 1'b1;
          state_d     = CONV;
        end
      end
      CONV: begin
        work_d = shifted;
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          res_d[fld_q] = shifted;
          work_d       = 12'd0;
          if (fld_q == 3'd5) state_d = COMMIT;
          else               fld_d   = fld_q + 3'd1;
        end
      end
      COMMIT: begin
        disp_bcd_d  = res_q;
        disp_mode_d = sh_mode_q;
        disp_pm_d   = sh_pm_q;
        busy_d      = 1'b0;
        valid_d     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Character generation reads only the display buffer plus live blink controls.
  always_comb begin
    int unsigned idx_i;
    int unsigned line_i;
    int unsigned col_i;
    logic [2:0]  dig_fld;
    logic [1:0]  dig_pos;
    logic [3:0]  nib;
    logic [7:0]  ch;
    idx_i   = 32'(idx);
    line_i  = idx_i / COLS;
    col_i   = idx_i % COLS;
    dig_fld = 3'd0;
    dig_pos = 2'd0;
    nib     = 4'd0;
    ch      = FILL;
    if (idx_i < TOTAL && col_i < 16 && line_i < 2 && disp_mode_q != 2'd3) begin
      if (line_i == 0) begin
        if (disp_mode_q == 2'd2) begin
          if (col_i < 9) ch = STOP_TXT[8*(15-col_i) +: 8];
        end else begin
          ch = LINE0_TXT[8*(15-col_i) +: 8];
          case (col_i)
            6:  begin dig_fld = 3'd1; dig_pos = 2'd2; end
            7:  begin dig_fld = 3'd1; dig_pos = 2'd1; end
            8:  begin dig_fld = 3'd1; dig_pos = 2'd0; end
            10: begin dig_fld = 3'd2; dig_pos = 2'd1; end
            11: begin dig_fld = 3'd2; dig_pos = 2'd0; end
            13: begin dig_fld = 3'd3; dig_pos = 2'd1; end
            14: begin dig_fld = 3'd3; dig_pos = 2'd0; end
            default: ;
          endcase
        end
      end else begin
        ch = LINE1_TXT[8*(15-col_i) +: 8];
        case (col_i)
          5:  begin dig_fld = 3'd4; dig_pos = 2'd1; end
          6:  begin dig_fld = 3'd4; dig_pos = 2'd0; end
          8:  begin dig_fld = 3'd5; dig_pos = 2'd1; end
          9:  begin dig_fld = 3'd5; dig_pos = 2'd0; end
          11: begin dig_fld = 3'd6; dig_pos = 2'd1; end
          12: begin dig_fld = 3'd6; dig_pos = 2'd0; end
          14: if (disp_mode_q == 2'd1) ch = disp_pm_q ? "P" : "A";
          15: if (disp_mode_q == 2'd1) ch = "M";
          default: ;
        endcase
      end
      if (dig_fld != 3'd0) begin
        nib = disp_bcd_q[dig_fld - 3'd1][4*dig_pos +: 4];
        ch  = (bus.blink_phase && bus.blink_sel == dig_fld) ? FILL : 8'h30 + {4'h0, nib};
      end
    end
    out_d = ch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fld_q       <= '0;
      bit_q       <= '0;
      work_q      <= '0;
      sh_bin_q    <= '{default: '0};
      res_q       <= '{default: '0};
      disp_bcd_q  <= '{default: '0};
      sh_mode_q   <= '0;
      disp_mode_q <= '0;
      sh_pm_q     <= 1'b0;
      disp_pm_q   <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      out_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      fld_q       <= fld_d;
      bit_q       <= bit_d;
      work_q      <= work_d;
      sh_bin_q    <= sh_bin_d;
      res_q       <= res_d;
      disp_bcd_q  <= disp_bcd_d;
      sh_mode_q   <= sh_mode_d;
      disp_mode_q <= disp_mode_d;
      sh_pm_q     <= sh_pm_d;
      disp_pm_q   <= disp_pm_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      out_q       <= out_d;
    end
  end
endmodule

// File: tb/tb_lcd_text_formatter.sv
// Directed bench for lcd_text_formatter: snapshot/convert/commit timing, layouts,
// 12h mapping, blinking, ignored loads, mid-conversion reset and padding.
module tb_lcd_text_formatter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  lcd_text_formatter_if #(.IDX_W(5)) bus ();
  lcd_text_formatter_if #(.IDX_W(6)) bus6 ();

  assign bus6.load        = bus.load;
  assign bus6.mode        = bus.mode;
  assign bus6.year        = bus.year;
  assign bus6.month       = bus.month;
  assign bus6.day         = bus.day;
  assign bus6.hour        = bus.hour;
  assign bus6.minute      = bus.minute;
  assign bus6.second      = bus.second;
  assign bus6.blink_sel   = bus.blink_sel;
  assign bus6.blink_phase = bus.blink_phase;

  lcd_text_formatter #(.COLS(16), .LINES(2), .IDX_W(5), .FILL(8'h20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  lcd_text_formatter #(.COLS(16), .LINES(2), .IDX_W(6), .FILL(8'h20)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply index at a negedge; the registered character is sampled one cycle later.
  task automatic rd(input int i, output logic [7:0] c);
    bus.index = 5'(i);
    @(negedge clk);
    c = bus.out;
  endtask

  task automatic rd_str(input int start, input int n, output logic [127:0] got);
    logic [7:0] c;
    got = '0;
    for (int k = 0; k < n; k++) begin
      rd(start + k, c);
      got = {got[119:0], c};
    end
  endtask

  task automatic do_load(input logic [1:0] m, input logic [7:0] y, input logic [7:0] mo,
                         input logic [7:0] d, input logic [7:0] h, input logic [7:0] mi,
                         input logic [7:0] s, input int pulse_at, output int ncyc);
    bus.mode = m; bus.year = y; bus.month = mo; bus.day = d;
    bus.hour = h; bus.minute = mi; bus.second = s;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    ncyc = 0;
    while (bus.busy && ncyc < 200) begin
      ncyc++;
      if (ncyc == pulse_at) begin
        bus.year = 8'd99; bus.month = 8'd12; bus.mode = 2'd3; bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
    $display("load mode=%0d y=%0d mo=%0d d=%0d h=%0d mi=%0d s=%0d busy_cycles=%0d valid=%0b",
             m, y, mo, d, h, mi, s, ncyc, bus.valid);
  endtask

  task automatic test_reset();
    logic [127:0] got;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", bus.out); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    rst = 1'b0;
    rd_str(0, 16, got);
    checks++; if (got !== "DATE 2000/00/00 ") begin failures++; $display("FAIL reset_line0 got=%h exp='DATE 2000/00/00 '", got); end
    rd_str(16, 16, got);
    checks++; if (got !== "TIME 00:00:00   ") begin failures++; $display("FAIL reset_line1 got=%h exp='TIME 00:00:00   '", got); end
  endtask

  task automatic test_basic();
    logic [127:0] got;
    logic [7:0]   c;
    int           n;
    do_load(2'd0, 8'd24, 8'd3, 8'd7, 8'd13, 8'd5, 8'd59, 0, n);
    checks++; if (n !== 49) begin failures++; $display("FAIL basic_busy_len got=%0d exp=49", n); end
    checks++; if (bus.valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.valid); end
    rd_str(5, 4, got);
    checks++; if (got !== "2024") begin failures++; $display("FAIL basic_year got=%h exp='2024'", got); end
    rd_str(10, 5, got);
    checks++; if (got !== "03/07") begin failures++; $display("FAIL basic_date got=%h exp='03/07'", got); end
    rd_str(21, 8, got);
    checks++; if (got !== "13:05:59") begin failures++; $display("FAIL basic_time got=%h exp='13:05:59'", got); end
    rd(31, c);
    checks++; if (c !== 8'h20) begin failures++; $display("FAIL basic_idx31 got=%h exp=20", c); end
    bus6.index = 6'd5;
    @(negedge clk);
    checks++; if (bus6.out !== 8'h32) begin failures++; $display("FAIL w6_idx5 got=%h exp=32", bus6.out); end
    bus6.index = 6'd32;
    @(negedge clk);
    checks++; if (bus6.out !== 8'h20) begin failures++; $display("FAIL w6_idx32 got=%h exp=20", bus6.out); end
  endtask

  task automatic test_12h();
    logic [127:0] got;
    logic [7:0]   c;
    int           n;
    do_load(2'd1, 8'd24, 8'd3, 8'd7, 8'd13, 8'd5, 8'd59, 0, n);
    rd_str(21, 2, got);
    checks++; if (got !== "01") begin failures++; $display("FAIL h12_13_hour got=%h exp='01'", got); end
    rd(29, c);
    checks++; if (c !== 8'h20) begin failures++; $display("FAIL h12_col13 got=%h exp=20", c); end
    rd_str(30, 2, got);
    checks++; if (got !== "PM") begin failures++; $display("FAIL h12_13_ampm got=%h exp='PM'", got); end
    do_load(2'd1, 8'd24, 8'd3, 8'd7, 8'd0, 8'd5, 8'd59, 0, n);
    rd_str(21, 2, got);
    checks++; if (got !== "12") begin failures++; $display("FAIL h12_0_hour got=%h exp='12'", got); end
    rd_str(30, 2, got);
    checks++; if (got !== "AM") begin failures++; $display("FAIL h12_0_ampm got=%h exp='AM'", got); end
    do_load(2'd1, 8'd24, 8'd3, 8'd7, 8'd12, 8'd5, 8'd59, 0, n);
    rd_str(21, 2, got);
    checks++; if (got !== "12") begin failures++; $display("FAIL h12_12_hour got=%h exp='12'", got); end
    rd_str(30, 2, got);
    checks++; if (got !== "PM") begin failures++; $display("FAIL h12_12_ampm got=%h exp='PM'", got); end
  endtask

  task automatic test_blink();
    logic [127:0] got;
    bus.blink_sel = 3'd5; bus.blink_phase = 1'b1;
    rd_str(23, 3, got);
    checks++; if (got !== 128'h3A2020) begin failures++; $display("FAIL blink_min_on got=%h exp=3a2020", got); end
    bus.blink_phase = 1'b0;
    rd_str(23, 3, got);
    checks++; if (got !== ":05") begin failures++; $display("FAIL blink_min_off got=%h exp=':05'", got); end
    bus.blink_sel = 3'd1; bus.blink_phase = 1'b1;
    rd_str(5, 5, got);
    checks++; if (got !== 128'h322020202F) begin failures++; $display("FAIL blink_year got=%h exp=322020202f", got); end
    bus.blink_sel = 3'd0; bus.blink_phase = 1'b0;
  endtask

  task automatic test_width();
    logic [127:0] got;
    int           n;
    do_load(2'd0, 8'd255, 8'd123, 8'd200, 8'd23, 8'd99, 8'd0, 0, n);
    rd_str(5, 10, got);
    checks++; if (got !== "2255/23/00") begin failures++; $display("FAIL width_date got=%h exp='2255/23/00'", got); end
    rd_str(21, 8, got);
    checks++; if (got !== "23:99:00") begin failures++; $display("FAIL width_time got=%h exp='23:99:00'", got); end
  endtask

  task automatic test_ignored_load();
    logic [127:0] got;
    int           n;
    do_load(2'd0, 8'd24, 8'd3, 8'd7, 8'd13, 8'd5, 8'd59, 10, n);
    checks++; if (n !== 49) begin failures++; $display("FAIL ignore_busy_len got=%0d exp=49", n); end
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ignore_no_restart got=%b exp=0", bus.busy); end
    rd_str(0, 9, got);
    checks++; if (got !== "DATE 2024") begin failures++; $display("FAIL ignore_frame got=%h exp='DATE 2024'", got); end
    rd_str(10, 2, got);
    checks++; if (got !== "03") begin failures++; $display("FAIL ignore_month got=%h exp='03'", got); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] got;
    int           n;
    bus.mode = 2'd0; bus.year = 8'd10; bus.month = 8'd1; bus.day = 8'd2;
    bus.hour = 8'd3; bus.minute = 8'd4; bus.second = 8'd5;
    bus.load = 1'b1;
    @(negedge clk);
    bus.year = 8'd11;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 49) begin failures++; $display("FAIL b2b_first_len got=%0d exp=49", n); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_next_accept got=%b exp=1", bus.busy); end
    bus.load = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    $display("load back_to_back y=11 busy_cycles=%0d valid=%0b", n, bus.valid);
    checks++; if (n !== 49) begin failures++; $display("FAIL b2b_second_len got=%0d exp=49", n); end
    rd_str(5, 4, got);
    checks++; if (got !== "2011") begin failures++; $display("FAIL b2b_year got=%h exp='2011'", got); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] got;
    int           n;
    bus.index = 5'd0;
    bus.mode = 2'd0; bus.year = 8'd77; bus.month = 8'd9; bus.day = 8'd9;
    bus.hour = 8'd9; bus.minute = 8'd9; bus.second = 8'd9;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.out !== 8'h00) begin failures++; $display("FAIL rmid_out got=%h exp=00", bus.out); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", bus.valid); end
    @(negedge clk);
    rst = 1'b0;
    rd_str(0, 16, got);
    checks++; if (got !== "DATE 2000/00/00 ") begin failures++; $display("FAIL rmid_frame got=%h exp='DATE 2000/00/00 '", got); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL rmid_valid_hold got=%b exp=0", bus.valid); end
    do_load(2'd0, 8'd30, 8'd12, 8'd31, 8'd23, 8'd59, 8'd58, 0, n);
    checks++; if (n !== 49) begin failures++; $display("FAIL rmid_reload_len got=%0d exp=49", n); end
    checks++; if (bus.valid !== 1'b1) begin failures++; $display("FAIL rmid_reload_valid got=%b exp=1", bus.valid); end
    rd_str(5, 10, got);
    checks++; if (got !== "2030/12/31") begin failures++; $display("FAIL rmid_reload_date got=%h exp='2030/12/31'", got); end
  endtask

  task automatic test_modes();
    logic [127:0] got;
    int           n;
    do_load(2'd2, 8'd24, 8'd3, 8'd7, 8'd13, 8'd5, 8'd59, 0, n);
    bus.blink_sel = 3'd2; bus.blink_phase = 1'b1;
    rd_str(0, 16, got);
    checks++; if (got !== "STOPWATCH       ") begin failures++; $display("FAIL sw_line0 got=%h exp='STOPWATCH       '", got); end
    rd_str(16, 16, got);
    checks++; if (got !== "TIME 13:05:59   ") begin failures++; $display("FAIL sw_line1 got=%h exp='TIME 13:05:59   '", got); end
    bus.blink_sel = 3'd0; bus.blink_phase = 1'b0;
    do_load(2'd3, 8'd24, 8'd3, 8'd7, 8'd13, 8'd5, 8'd59, 0, n);
    rd_str(0, 16, got);
    checks++; if (got !== "                ") begin failures++; $display("FAIL blank_line0 got=%h exp=all 20", got); end
    rd_str(16, 16, got);
    checks++; if (got !== "                ") begin failures++; $display("FAIL blank_line1 got=%h exp=all 20", got); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.load = 1'b0; bus.mode = 2'd0;
    bus.year = 8'd0; bus.month = 8'd0; bus.day = 8'd0;
    bus.hour = 8'd0; bus.minute = 8'd0; bus.second = 8'd0;
    bus.blink_sel = 3'd0; bus.blink_phase = 1'b0;
    bus.index = 5'd0; bus6.index = 6'd0;
    test_reset();
    test_basic();
    test_12h();
    test_blink();
    test_width();
    test_ignored_load();
    test_back_to_back();
    test_reset_mid();
    test_modes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog timeout");
  end
endmodule
